gpio_input_distributor: RTL and testbench

Input-side counterpart of the per-pin GPIO output arbitration. Takes the 32 asynchronous GPIO input pins, synchronises them, applies an optional glitch filter, records sticky edge events and distributes the filtered pin vector to the 4 PIO cores. Each core can freeze its own view of the pins.

---
 rtl/gpio_input_distributor.sv | 180 ++++++++++++++++++
 tb/tb_gpio_input_distributor.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_distributor.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_distributor
// Purpose  : Input side of the GPIO block. Brings the asynchronous pin levels
//            into the clock domain (optional 2-flop synchroniser per pin),
//            applies a programmable glitch filter, records sticky rise/fall
//            events and fans the filtered pin vector out to every PIO core.
//            Each core may freeze its own copy of the pins.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset, released synchronously
//   gpio_input     raw asynchronous pin levels
//   sync_bypass    per pin, 1 = take the raw pin instead of the synchroniser
//   filter_cycles  glitch-filter length in cycles, 0 = filter disabled
//   core_input_en  per core, 1 = view tracks pin_value, 0 = view frozen
//   edge_clear     write-1-to-clear for rise_flag / fall_flag
//   pin_value      filtered pin levels
//   core_input     per-core registered copy of pin_value
//   rise_flag      sticky 0->1 events seen on pin_value
//   fall_flag      sticky 1->0 events seen on pin_value
// ============================================================================
module gpio_input_distributor #(
  parameter int NUM_PINS  = 32,
  parameter int NUM_CORES = 4,
  parameter int FILTER_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PINS-1:0]  gpio_input,
  input  logic [NUM_PINS-1:0]  sync_bypass,
  input  logic [FILTER_W-1:0]  filter_cycles,
  input  logic [NUM_CORES-1:0] core_input_en,
  input  logic [NUM_PINS-1:0]  edge_clear,
  output logic [NUM_PINS-1:0]  pin_value,
  output logic [NUM_PINS-1:0]  core_input [NUM_CORES-1:0],
  output logic [NUM_PINS-1:0]  rise_flag,
  output logic [NUM_PINS-1:0]  fall_flag
);

  localparam logic [FILTER_W-1:0] c_CNT_ZERO = '0;
  localparam logic [FILTER_W-1:0] c_CNT_ONE  = {{(FILTER_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [NUM_PINS-1:0] r_sync1;
  logic [NUM_PINS-1:0] r_sync2;
  logic [FILTER_W-1:0] r_cnt [NUM_PINS];
  logic [NUM_PINS-1:0] r_pin_value;
  logic [NUM_PINS-1:0] r_pv_d;
  logic [FILTER_W-1:0] r_fc_d;
  logic [NUM_PINS-1:0] r_rise;
  logic [NUM_PINS-1:0] r_fall;
  logic [NUM_PINS-1:0] r_core [NUM_CORES];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [NUM_PINS-1:0] w_src;
  logic                w_fc_changed;
  logic                w_filter_off;
  logic [FILTER_W-1:0] w_cnt_limit;
  logic [NUM_PINS-1:0] w_pv_next;
  logic [FILTER_W-1:0] w_cnt_next [NUM_PINS];
  logic [NUM_PINS-1:0] w_rise_evt;
  logic [NUM_PINS-1:0] w_fall_evt;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser. The bypass select is purely combinational so a
  // pin can be switched between raw and synchronised at any time.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_input;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = (sync_bypass & gpio_input) | (~sync_bypass & r_sync2);

  // --------------------------------------------------------------------------
  // Glitch filter
  // A pin accepts a new level only after src has disagreed with pin_value on
  // N consecutive cycles; the counter therefore tops out at N-1 and the
  // accepting cycle is the one where it already holds N-1. A change of
  // filter_cycles restarts every counter and freezes pin_value for that
  // cycle so no pin is judged against a half-old, half-new threshold.
  // --------------------------------------------------------------------------
  assign w_fc_changed = (filter_cycles != r_fc_d);
  assign w_filter_off = (filter_cycles == c_CNT_ZERO);
  assign w_cnt_limit  = filter_cycles - c_CNT_ONE;

  always_comb begin
    w_pv_next = r_pin_value;
    for (int i = 0; i < NUM_PINS; i++) begin
      w_cnt_next[i] = r_cnt[i];
    end

    for (int i = 0; i < NUM_PINS; i++) begin
      if (w_fc_changed) begin
        w_cnt_next[i] = c_CNT_ZERO;
      end else if (w_filter_off) begin
        w_pv_next[i]  = w_src[i];
        w_cnt_next[i] = c_CNT_ZERO;
      end else if (w_src[i] == r_pin_value[i]) begin
        w_cnt_next[i] = c_CNT_ZERO;
      end else if (r_cnt[i] == w_cnt_limit) begin
        w_pv_next[i]  = w_src[i];
        w_cnt_next[i] = c_CNT_ZERO;
      end else begin
        w_cnt_next[i] = r_cnt[i] + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin_value <= '0;
      r_fc_d      <= '0;
      for (int i = 0; i < NUM_PINS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_pin_value <= w_pv_next;
      r_fc_d      <= filter_cycles;
      for (int i = 0; i < NUM_PINS; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky edge flags. pv_d and pin_value both reset to 0, so the first
  // cycle after reset cannot produce a spurious event. The event term is
  // OR-ed after the clear mask so a same-cycle event beats the clear.
  // --------------------------------------------------------------------------
  assign w_rise_evt =  r_pin_value & ~r_pv_d;
  assign w_fall_evt = ~r_pin_value &  r_pv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv_d <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_pv_d <= r_pin_value;
      r_rise <= w_rise_evt | (r_rise & ~edge_clear);
      r_fall <= w_fall_evt | (r_fall & ~edge_clear);
    end
  end

  // --------------------------------------------------------------------------
  // Per-core views. Every enabled core takes the same pin_value; a disabled
  // core simply stops loading and keeps its last snapshot.
  // --------------------------------------------------------------------------
  generate
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_core[c] <= '0;
        end else if (core_input_en[c]) begin
          r_core[c] <= r_pin_value;
        end
      end

      assign core_input[c] = r_core[c];
    end
  endgenerate

  assign pin_value = r_pin_value;
  assign rise_flag = r_rise;
  assign fall_flag = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input_distributor
// Purpose  : Self-checking bench for gpio_input_distributor. A cycle-level
//            reference model (consecutive-mismatch run lengths, a sample
//            history for the synchroniser) is advanced alongside the DUT;
//            directed scenarios also check literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_distributor;

  localparam int NP = 32;
  localparam int NC = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NP-1:0] gpio_input = '0;
  logic [NP-1:0] sync_bypass = '0;
  logic [FW-1:0] filter_cycles = '0;
  logic [NC-1:0] core_input_en = '0;
  logic [NP-1:0] edge_clear = '0;
  logic [NP-1:0] pin_value;
  logic [NP-1:0] core_input [NC-1:0];
  logic [NP-1:0] rise_flag;
  logic [NP-1:0] fall_flag;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [NP-1:0] m_s1, m_s2, m_pv, m_pvd, m_rise, m_fall;
  logic [FW-1:0] m_fc_prev;
  logic [NP-1:0] m_core [NC];
  int            m_run  [NP];

  gpio_input_distributor #(
    .NUM_PINS (NP),
    .NUM_CORES(NC),
    .FILTER_W (FW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gpio_input   (gpio_input),
    .sync_bypass  (sync_bypass),
    .filter_cycles(filter_cycles),
    .core_input_en(core_input_en),
    .edge_clear   (edge_clear),
    .pin_value    (pin_value),
    .core_input   (core_input),
    .rise_flag    (rise_flag),
    .fall_flag    (fall_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_pv = '0; m_pvd = '0;
    m_rise = '0; m_fall = '0; m_fc_prev = '0;
    for (int c = 0; c < NC; c++) m_core[c] = '0;
    for (int i = 0; i < NP; i++) m_run[i] = 0;
  endtask

  // Advance the model by one clock using the inputs as currently driven,
  // then let the DUT take the same edge and settle.
  task automatic step();
    logic [NP-1:0] src, npv, rev, fev;
    src = (sync_bypass & gpio_input) | (~sync_bypass & m_s2);
    npv = m_pv;
    for (int i = 0; i < NP; i++) begin
      if (filter_cycles != m_fc_prev) begin
        m_run[i] = 0;
      end else if (filter_cycles == 0) begin
        npv[i] = src[i];
        m_run[i] = 0;
      end else if (src[i] == m_pv[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == int'(filter_cycles)) begin
          npv[i] = src[i];
          m_run[i] = 0;
        end
      end
    end
    rev = m_pv & ~m_pvd;
    fev = ~m_pv & m_pvd;
    m_rise = rev | (m_rise & ~edge_clear);
    m_fall = fev | (m_fall & ~edge_clear);
    for (int c = 0; c < NC; c++) if (core_input_en[c]) m_core[c] = m_pv;
    m_pvd = m_pv;
    m_pv  = npv;
    m_s2  = m_s1;
    m_s1  = gpio_input;
    m_fc_prev = filter_cycles;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    gpio_input = 32'hFFFF_FFFF;
    sync_bypass = '0;
    filter_cycles = '0;
    core_input_en = 4'hF;
    edge_clear = '0;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (pin_value !== 32'h0) begin
      n_err++; $display("FAIL reset_pin_value: got %h expected %h", pin_value, 32'h0);
    end
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (core_input[c] !== 32'h0) begin
        n_err++; $display("FAIL reset_core_input[%0d]: got %h expected %h", c, core_input[c], 32'h0);
      end
    end
    n_cmp++;
    if (rise_flag !== 32'h0 || fall_flag !== 32'h0) begin
      n_err++; $display("FAIL reset_flags: got rise %h fall %h expected 0 0", rise_flag, fall_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step();
      n_cmp++;
      if (pin_value !== 32'h0) begin
        n_err++; $display("FAIL reset_early_pv edge %0d: got %h expected %h", e, pin_value, 32'h0);
      end
    end
    step();
    n_cmp++;
    if (pin_value !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL reset_pv_edge3: got %h expected %h", pin_value, 32'hFFFF_FFFF);
    end
    n_cmp++;
    if (rise_flag !== 32'h0) begin
      n_err++; $display("FAIL reset_rise_edge3: got %h expected %h", rise_flag, 32'h0);
    end
    step();
    n_cmp++;
    if (rise_flag !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL reset_rise_edge4: got %h expected %h", rise_flag, 32'hFFFF_FFFF);
    end
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (core_input[c] !== 32'hFFFF_FFFF) begin
        n_err++; $display("FAIL reset_core_edge4[%0d]: got %h expected %h", c, core_input[c], 32'hFFFF_FFFF);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_bypass();
    gpio_input = '0;
    sync_bypass = 32'h1;
    filter_cycles = '0;
    core_input_en = 4'hF;
    edge_clear = '0;
    do_reset();
    repeat (3) step();
    gpio_input = 32'h3;
    step();
    n_cmp++;
    if (pin_value[1:0] !== 2'b01) begin
      n_err++; $display("FAIL bypass_edge_k: got %b expected %b", pin_value[1:0], 2'b01);
    end
    step();
    n_cmp++;
    if (pin_value[1:0] !== 2'b01) begin
      n_err++; $display("FAIL bypass_edge_k1: got %b expected %b", pin_value[1:0], 2'b01);
    end
    step();
    n_cmp++;
    if (pin_value[1:0] !== 2'b11) begin
      n_err++; $display("FAIL bypass_edge_k2: got %b expected %b", pin_value[1:0], 2'b11);
    end
    n_cmp++;
    if (pin_value !== m_pv) begin
      n_err++; $display("FAIL bypass_model: got %h expected %h", pin_value, m_pv);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_glitch();
    gpio_input = '0;
    sync_bypass = '0;
    filter_cycles = 4'd4;
    core_input_en = 4'hF;
    edge_clear = '0;
    do_reset();
    repeat (3) step();
    gpio_input = 32'h20;
    repeat (3) step();
    gpio_input = 32'h0;
    for (int n = 0; n < 8; n++) begin
      step();
      n_cmp++;
      if (pin_value[5] !== 1'b0) begin
        n_err++; $display("FAIL glitch_blocked cyc %0d: got %b expected %b", n, pin_value[5], 1'b0);
      end
    end
    n_cmp++;
    if (rise_flag[5] !== 1'b0) begin
      n_err++; $display("FAIL glitch_rise: got %b expected %b", rise_flag[5], 1'b0);
    end
    gpio_input = 32'h20;
    for (int n = 0; n < 5; n++) begin
      step();
      n_cmp++;
      if (pin_value[5] !== 1'b0) begin
        n_err++; $display("FAIL glitch_wait edge k+%0d: got %b expected %b", n, pin_value[5], 1'b0);
      end
    end
    step();
    n_cmp++;
    if (pin_value[5] !== 1'b1) begin
      n_err++; $display("FAIL glitch_pass edge k+5: got %b expected %b", pin_value[5], 1'b1);
    end
    n_cmp++;
    if (pin_value !== m_pv) begin
      n_err++; $display("FAIL glitch_model: got %h expected %h", pin_value, m_pv);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_edge_race();
    gpio_input = '0;
    sync_bypass = '1;
    filter_cycles = '0;
    core_input_en = 4'hF;
    edge_clear = '0;
    do_reset();
    repeat (2) step();
    gpio_input = 32'h80;
    step();
    n_cmp++;
    if (pin_value[7] !== 1'b1 || rise_flag[7] !== 1'b0) begin
      n_err++; $display("FAIL race_pv: got pv %b rise %b expected 1 0", pin_value[7], rise_flag[7]);
    end
    edge_clear = 32'h80;
    step();
    n_cmp++;
    if (rise_flag[7] !== 1'b1) begin
      n_err++; $display("FAIL race_set_wins: got %b expected %b", rise_flag[7], 1'b1);
    end
    step();
    n_cmp++;
    if (rise_flag[7] !== 1'b0) begin
      n_err++; $display("FAIL race_clear: got %b expected %b", rise_flag[7], 1'b0);
    end
    edge_clear = '0;
    gpio_input = '0;
    step();
    step();
    n_cmp++;
    if (fall_flag[7] !== 1'b1 || rise_flag[7] !== 1'b0) begin
      n_err++; $display("FAIL race_fall: got fall %b rise %b expected 1 0", fall_flag[7], rise_flag[7]);
    end
    n_cmp++;
    if (rise_flag !== m_rise || fall_flag !== m_fall) begin
      n_err++; $display("FAIL race_model: got %h/%h expected %h/%h", rise_flag, fall_flag, m_rise, m_fall);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_core_freeze();
    gpio_input = '0;
    sync_bypass = '0;
    filter_cycles = '0;
    core_input_en = 4'b1101;
    edge_clear = '0;
    do_reset();
    repeat (2) step();
    gpio_input = 32'hA5A5_A5A5;
    repeat (4) step();
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (core_input[c] !== ((c == 1) ? 32'h0 : 32'hA5A5_A5A5)) begin
        n_err++; $display("FAIL freeze_core[%0d]: got %h expected %h", c, core_input[c],
                          (c == 1) ? 32'h0 : 32'hA5A5_A5A5);
      end
    end
    core_input_en = 4'b1111;
    step();
    n_cmp++;
    if (core_input[1] !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL freeze_reenable: got %h expected %h", core_input[1], 32'hA5A5_A5A5);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_filter_change();
    gpio_input = '0;
    sync_bypass = '1;
    filter_cycles = 4'd6;
    core_input_en = 4'hF;
    edge_clear = '0;
    do_reset();
    repeat (3) step();
    gpio_input = 32'h8;
    for (int n = 0; n < 4; n++) begin
      step();
      n_cmp++;
      if (pin_value[3] !== 1'b0) begin
        n_err++; $display("FAIL fchg_counting %0d: got %b expected %b", n, pin_value[3], 1'b0);
      end
    end
    filter_cycles = 4'd2;
    for (int n = 0; n < 2; n++) begin
      step();
      n_cmp++;
      if (pin_value[3] !== 1'b0) begin
        n_err++; $display("FAIL fchg_restart %0d: got %b expected %b", n, pin_value[3], 1'b0);
      end
    end
    step();
    n_cmp++;
    if (pin_value[3] !== 1'b1) begin
      n_err++; $display("FAIL fchg_update: got %b expected %b", pin_value[3], 1'b1);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    gpio_input = $urandom;
    sync_bypass = '0;
    filter_cycles = 4'd5;
    core_input_en = 4'hF;
    edge_clear = '0;
    do_reset();
    repeat (10) step();
    n_cmp++;
    if (pin_value !== m_pv) begin
      n_err++; $display("FAIL areset_pre: got %h expected %h", pin_value, m_pv);
    end
    gpio_input = ~gpio_input;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (pin_value !== 32'h0 || rise_flag !== 32'h0 || fall_flag !== 32'h0) begin
      n_err++; $display("FAIL areset_out: got %h %h %h expected 0 0 0", pin_value, rise_flag, fall_flag);
    end
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (core_input[c] !== 32'h0) begin
        n_err++; $display("FAIL areset_core[%0d]: got %h expected %h", c, core_input[c], 32'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) step();
    n_cmp++;
    if (pin_value !== m_pv) begin
      n_err++; $display("FAIL areset_recover: got %h expected %h", pin_value, m_pv);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    gpio_input = '0;
    sync_bypass = '0;
    filter_cycles = '0;
    core_input_en = 4'hF;
    edge_clear = '0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ((n % 3) == 0) gpio_input = gpio_input ^ ($urandom & $urandom & $urandom);
      if ((n % 50) == 0) sync_bypass = $urandom;
      if ((n % 37) == 0) filter_cycles = FW'($urandom_range(0, 5));
      if ((n % 8) == 0) core_input_en = NC'($urandom);
      edge_clear = $urandom & $urandom & $urandom;
      step();
      n_cmp++;
      if (pin_value !== m_pv) begin
        n_err++; $display("FAIL rand_pv cyc %0d: got %h expected %h", n, pin_value, m_pv);
      end
      n_cmp++;
      if (rise_flag !== m_rise) begin
        n_err++; $display("FAIL rand_rise cyc %0d: got %h expected %h", n, rise_flag, m_rise);
      end
      n_cmp++;
      if (fall_flag !== m_fall) begin
        n_err++; $display("FAIL rand_fall cyc %0d: got %h expected %h", n, fall_flag, m_fall);
      end
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (core_input[c] !== m_core[c]) begin
          n_err++; $display("FAIL rand_core[%0d] cyc %0d: got %h expected %h", c, n, core_input[c], m_core[c]);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_bypass();
    test_glitch();
    test_edge_race();
    test_core_freeze();
    test_filter_change();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
